// File: rtl/uarch_trace_pkg.sv
// Shared types and helpers for the pipeline trace collector.
// Holds the serializer state encoding, event-count helper and lowest-set-bit search.
package uarch_trace_pkg;

    localparam int MAX_EV = 64;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } ser_state_t;

    function automatic int num_ev(input int stages, input int lanes);
        return stages * lanes;
    endfunction

    // Scanning downwards leaves the lowest set index in idx.
    function automatic int lowest_set(input logic [MAX_EV-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_EV - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/uarch_trace_snap_fifo.sv
// Generic synchronous FIFO; one-cycle write-to-read, push and pop may coincide when full.
// The caller gates push against full itself, so no write is ever refused here.
module uarch_trace_snap_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_pop_dat = r_mem[r_rptr];
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/uarch_trace_collector.sv
// Captures active stage/lane cycles into a snapshot FIFO and serialises one record per event.
// First record two cycles after capture; outputs hold under !out_ready, full FIFO drops are counted.
module uarch_trace_collector
    import uarch_trace_pkg::*;
#(
    parameter int NUM_STAGES = 8,
    parameter int NUM_LANES  = 2,
    parameter int PC_W       = 32,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16,
    localparam int NUM_EV    = num_ev(NUM_STAGES, NUM_LANES),
    localparam int STG_W     = $clog2(NUM_STAGES),
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en,
    input  logic [NUM_EV-1:0]      ev_valid,
    input  logic [NUM_EV*PC_W-1:0] ev_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STG_W-1:0]       out_stage,
    output logic [LANE_W-1:0]      out_lane,
    output logic [PC_W-1:0]        out_pc,
    output logic [TS_W-1:0]        out_ts,
    output logic                   out_last,
    output logic                   out_gap,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   overflow
);
    typedef struct packed {
        logic [NUM_EV-1:0]      mask;
        logic [NUM_EV*PC_W-1:0] pcs;
        logic [TS_W-1:0]        ts;
        logic                   gap;
    } snap_t;

    snap_t                  w_push_snap;
    snap_t                  w_head;
    logic                   w_full, w_empty;
    logic                   w_active, w_pop, w_push, w_drop, w_accept, w_last;
    int                     w_e;
    ser_state_t             r_state, w_state_nxt;
    logic [TS_W-1:0]        r_ts;
    logic                   r_pend_gap;
    logic                   r_ovf;
    logic [DROP_W-1:0]      r_drop;
    logic [NUM_EV-1:0]      r_mask;
    logic [NUM_EV*PC_W-1:0] r_pcs;
    logic [TS_W-1:0]        r_wts;
    logic                   r_gap;
    logic                   r_first;

    assign w_active    = trace_en && (|ev_valid);
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign w_push      = w_active && (!w_full || w_pop);
    assign w_drop      = w_active && w_full && !w_pop;
    assign w_accept    = (r_state == S_EMIT) && out_ready;
    assign w_last      = ((r_mask & (r_mask - 1'b1)) == '0);
    assign w_e         = lowest_set(MAX_EV'(r_mask));
    assign w_push_snap = '{mask: ev_valid, pcs: ev_pc, ts: r_ts, gap: r_pend_gap};

    uarch_trace_snap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(snap_t))
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_snap),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts       <= '0;
            r_pend_gap <= 1'b0;
            r_ovf      <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_push)      r_pend_gap <= 1'b0;
            else if (w_drop) r_pend_gap <= 1'b1;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_EMIT;
            S_EMIT:  if (out_ready && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working copy of the snapshot; each accepted record retires the lowest mask bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_pcs   <= '0;
            r_wts   <= '0;
            r_gap   <= 1'b0;
            r_first <= 1'b0;
        end else if (w_pop) begin
            r_mask  <= w_head.mask;
            r_pcs   <= w_head.pcs;
            r_wts   <= w_head.ts;
            r_gap   <= w_head.gap;
            r_first <= 1'b1;
        end else if (w_accept) begin
            r_mask  <= r_mask & (r_mask - 1'b1);
            r_first <= 1'b0;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_stage = '0;
        out_lane  = '0;
        out_pc    = '0;
        out_ts    = '0;
        out_last  = 1'b0;
        out_gap   = 1'b0;
        if (!rst && (r_state == S_EMIT)) begin
            out_valid = 1'b1;
            out_stage = STG_W'(w_e / NUM_LANES);
            out_lane  = LANE_W'(w_e % NUM_LANES);
            out_pc    = r_pcs[w_e*PC_W +: PC_W];
            out_ts    = r_wts;
            out_last  = w_last;
            out_gap   = r_gap && r_first;
        end
    end

    assign drop_cnt = rst ? '0 : r_drop;
    assign overflow = !rst && r_ovf;

endmodule

// File: tb/tb_uarch_trace_collector.sv
// Randomised bench for uarch_trace_collector against a snapshot-queue reference model.
// TS_W is shrunk to 4 so timestamp wrap happens many times during the run.
module tb_uarch_trace_collector;

    localparam int NS    = 8;
    localparam int NL    = 2;
    localparam int NEV   = NS * NL;
    localparam int PCW   = 32;
    localparam int TSW   = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               trace_en = 1'b0;
    logic [NEV-1:0]     ev_valid = '0;
    logic [NEV*PCW-1:0] ev_pc = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [2:0]         out_stage;
    logic [0:0]         out_lane;
    logic [PCW-1:0]     out_pc;
    logic [TSW-1:0]     out_ts;
    logic               out_last;
    logic               out_gap;
    logic [DW-1:0]      drop_cnt;
    logic               overflow;

    uarch_trace_collector #(
        .NUM_STAGES (NS),
        .NUM_LANES  (NL),
        .PC_W       (PCW),
        .TS_W       (TSW),
        .FIFO_DEPTH (DEPTH),
        .DROP_W     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trace_en  (trace_en),
        .ev_valid  (ev_valid),
        .ev_pc     (ev_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_stage (out_stage),
        .out_lane  (out_lane),
        .out_pc    (out_pc),
        .out_ts    (out_ts),
        .out_last  (out_last),
        .out_gap   (out_gap),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NEV-1:0]     mask;
        logic [NEV*PCW-1:0] pcs;
        logic [TSW-1:0]     ts;
        logic               gap;
    } snap_s;

    // Reference: queued snapshots, records of the snapshot being emitted, counters.
    snap_s       m_q[$];
    logic [63:0] m_exp[$];
    int          m_ts;
    int          m_drop;
    bit          m_ovf;
    bit          m_pgap;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NEV*PCW-1:0] rand_pcs();
        logic [NEV*PCW-1:0] r;
        for (int i = 0; i < NEV; i++) r[i*PCW +: PCW] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] obs_rec();
        return {22'd0, out_stage, out_lane, out_pc, out_ts, out_last, out_gap};
    endfunction

    task automatic expand(input snap_s s);
        int hi;
        bit first;
        hi = -1;
        for (int e = 0; e < NEV; e++) if (s.mask[e]) hi = e;
        first = 1'b1;
        for (int e = 0; e < NEV; e++) begin
            if (s.mask[e]) begin
                m_exp.push_back({22'd0, 3'(e / NL), 1'(e % NL), s.pcs[e*PCW +: PCW],
                                 s.ts, (e == hi), (s.gap && first)});
                first = 1'b0;
            end
        end
    endtask

    // Called at a falling edge: check the current cycle, drive inputs, advance the model.
    task automatic cycle(input logic en, input logic [NEV-1:0] ev,
                         input logic [NEV*PCW-1:0] pcs, input logic rdy);
        bit    pop;
        bit    push_ok;
        snap_s s;
        chk("out_valid", out_valid, m_exp.size() != 0);
        if (m_exp.size() != 0) chk("record", obs_rec(), m_exp[0]);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow", overflow, m_ovf);
        trace_en  = en;
        ev_valid  = ev;
        ev_pc     = pcs;
        out_ready = rdy;
        pop     = (m_exp.size() == 0) && (m_q.size() != 0);
        push_ok = (m_q.size() < DEPTH) || pop;
        if (m_exp.size() != 0 && rdy) void'(m_exp.pop_front());
        if (pop) begin
            s = m_q.pop_front();
            expand(s);
        end
        if (en && (|ev)) begin
            if (push_ok) begin
                m_q.push_back('{mask: ev, pcs: pcs, ts: TSW'(m_ts), gap: m_pgap});
                m_pgap = 1'b0;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf  = 1'b1;
                m_pgap = 1'b1;
            end
        end
        m_ts = (m_ts + 1) % (1 << TSW);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        trace_en  = 1'b0;
        ev_valid  = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_exp.delete();
        m_ts   = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        m_pgap = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (m_exp.size() != 0 || m_q.size() != 0); i++)
            cycle(1'b0, '0, rand_pcs(), 1'b1);
        cycle(1'b0, '0, rand_pcs(), 1'b1);
    endtask

    initial begin
        logic [NEV*PCW-1:0] pcs;
        logic [NEV-1:0]     ev;
        do_reset();

        // Single event at ts=7 shows up at ts=9.
        for (int i = 0; i < 16 && m_ts != 7; i++) cycle(1'b0, '0, rand_pcs(), 1'b1);
        pcs = rand_pcs();
        pcs[5*PCW +: PCW] = 32'h8000_0010;
        cycle(1'b1, 16'h0020, pcs, 1'b1);
        cycle(1'b0, '0, rand_pcs(), 1'b1);
        chk("single_ts_now", 64'(m_ts), 9);
        chk("single_rec", {out_valid, obs_rec()}, {1'b1, 22'd0, 3'd2, 1'b1, 32'h8000_0010, 4'd7, 1'b1, 1'b0});
        drain();

        // Three events in one cycle leave in ascending index order.
        cycle(1'b1, 16'h8003, rand_pcs(), 1'b1);
        cycle(1'b0, '0, rand_pcs(), 1'b1);
        chk("multi_e0", {out_valid, out_stage, out_lane, out_last}, {1'b1, 3'd0, 1'b0, 1'b0});
        cycle(1'b0, '0, rand_pcs(), 1'b1);
        chk("multi_e1", {out_valid, out_stage, out_lane, out_last}, {1'b1, 3'd0, 1'b1, 1'b0});
        cycle(1'b0, '0, rand_pcs(), 1'b1);
        chk("multi_e15", {out_valid, out_stage, out_lane, out_last}, {1'b1, 3'd7, 1'b1, 1'b1});
        drain();

        // Held under backpressure, then released.
        cycle(1'b1, 16'h0F0F, rand_pcs(), 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, rand_pcs(), 1'b0);
        drain();

        // Stalled serializer plus ten active cycles: eight fit, two drop.
        cycle(1'b1, 16'h0001, rand_pcs(), 1'b0);
        cycle(1'b0, '0, rand_pcs(), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'h0001 << (i % NEV), rand_pcs(), 1'b0);
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_sticky", overflow, 1);
        drain();
        cycle(1'b1, 16'h0004, rand_pcs(), 1'b1);
        cycle(1'b0, '0, rand_pcs(), 1'b1);
        chk("gap_first", {out_valid, out_gap}, 2'b11);
        drain();

        // Random traffic with toggling enable and bursty ready.
        for (int i = 0; i < 500; i++) begin
            ev = (($urandom_range(0, 3) == 0) ? NEV'($urandom) : (NEV'($urandom) & NEV'($urandom) & NEV'($urandom)));
            cycle($urandom_range(0, 3) != 0, ev, rand_pcs(), $urandom_range(0, 4) != 0);
        end
        drain();

        // Reset while emitting with three snapshots queued.
        cycle(1'b1, 16'h0003, rand_pcs(), 1'b0);
        cycle(1'b0, '0, rand_pcs(), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h00F0, rand_pcs(), 1'b0);
        do_reset();
        cycle(1'b1, 16'h0100, rand_pcs(), 1'b1);
        cycle(1'b0, '0, rand_pcs(), 1'b1);
        chk("post_rst_ts", {out_valid, out_ts}, {1'b1, 4'd0});
        for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 1) != 0, NEV'($urandom), rand_pcs(), $urandom_range(0, 2) != 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/uarch_trace_collector.md
Name: uarch_trace_collector

Overview:
Parametrised successor to the per-stage DPI trace hook. Samples a configurable grid of pipeline stages × issue lanes each cycle and timestamps every cycle that has activity. Buffers those cycles in a snapshot FIFO and serialises them into a valid/ready record stream (one record per stage/lane event). Overflow is detected, counted and flagged instead of silently lost. Sits beside the core and feeds either a DPI sink or an on-chip trace port.

Parameters:
NUM_STAGES, 8, number of traced pipeline stages (stage 0 = alignment … NUM_STAGES-1 = writeback)
NUM_LANES, 2, issue lanes per stage
PC_W, 32, PC width
TS_W, 32, timestamp width
FIFO_DEPTH, 8, snapshot FIFO entries (power of 2, ≥2)
DROP_W, 16, drop counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
trace_en  in  1  capture enable
ev_valid  in  NUM_STAGES*NUM_LANES  event valid; index e = stage*NUM_LANES+lane
ev_pc  in  NUM_STAGES*NUM_LANES*PC_W  event PCs; slice e = [e*PC_W +: PC_W]
out_valid  out  1  record valid
out_ready  in  1  sink accept
out_stage  out  $clog2(NUM_STAGES)  stage id
out_lane  out  max(1,$clog2(NUM_LANES))  lane id
out_pc  out  PC_W  PC
out_ts  out  TS_W  timestamp of the sample cycle
out_last  out  1  last record of its cycle
out_gap  out  1  one or more cycles were dropped before this record
drop_cnt  out  DROP_W  dropped-cycle count, saturating
overflow  out  1  sticky; set on first drop

Behaviour:
- Reset. Synchronous. All outputs are 0 while rst is high and in the cycle after it. This includes out_valid, drop_cnt and overflow.
- Reset clears the timestamp counter, FIFO pointers/count, serializer state and pending_gap. Mid-operation reset discards all buffered and in-flight records.
- Timestamp. Free-running TS_W counter. Increments every cycle rst is low, regardless of trace_en. Wraps modulo 2^TS_W. The first cycle after reset has ts = 0.
- Capture. A cycle is "active" if trace_en=1 and |ev_valid. For an active cycle, one snapshot is pushed: {mask=ev_valid, all ev_pc, ts, gap=pending_gap}. Inactive cycles push nothing.
- Push acceptance. A push is accepted if count<FIFO_DEPTH, or a pop occurs in the same cycle.
- Drop. On an active cycle whose push is refused:
  - drop_cnt increments, saturating at all-ones.
  - overflow is set (sticky until reset).
  - pending_gap is set.
- pending_gap clears on the next accepted push, which carries gap=1.
- Serializer FSM:
  - IDLE: if FIFO non-empty, pop the head into working registers (mask, pcs, ts, gap) and go to EMIT.
  - EMIT: out_valid=1. Current event = lowest set index in the working mask. Outputs: out_stage = e/NUM_LANES, out_lane = e%NUM_LANES, out_pc = pc[e], out_ts = ts, out_gap = gap and this is the first record of the snapshot, out_last = exactly one mask bit remains.
  - On out_valid&&out_ready: clear bit e. If it was the last bit, go to IDLE.
  - A one-cycle bubble between snapshots is allowed.
- Latency. An event sampled at the edge ending cycle N is presented at the earliest in cycle N+2 (FIFO empty, serializer IDLE).
- Handshake. While out_valid=1 and out_ready=0, all out_* fields are held stable. out_valid never drops without acceptance, except on rst.
- Ordering. Records leave in cycle order. Within a cycle, they leave in ascending event index.
- trace_en low. No capture. Already-buffered snapshots continue to drain.
- Simultaneous pop and push with a full FIFO: both are accepted; no drop.

Decomposition:
- Package uarch_trace_pkg:
  - NUM_EV localparam helper
  - function for lowest-set-bit index
  - parametrised snapshot struct (mask, pcs, ts, gap)
  - serializer state enum {IDLE, EMIT}
- Sub-module uarch_trace_snap_fifo: generic synchronous FIFO (DEPTH, W) with push/pop/full/empty/count and simultaneous push-pop when full.
- The collector holds the capture logic, timestamp, drop logic and serializer.

Test Plan:
- Single event (defaults): ev_valid=bit5 (stage2 lane1), pc=0x80000010, at ts=7, out_ready=1 → one record in cycle ts=9 with stage=2, lane=1, pc=0x80000010, ts=7, last=1, gap=0.
- Multi-event cycle: mask=0x8003 in one cycle → three records in order e=0,1,15; same ts; last=1 only on e=15.
- Backpressure: out_ready=0 for 10 cycles while records are pending → out_valid held, fields unchanged. Release → each record emitted exactly once.
- Overflow: out_ready=0, 10 consecutive active cycles, FIFO_DEPTH=8 → drop_cnt=2, overflow=1. After drain, the 9th-cycle snapshot is never emitted. The next accepted cycle's first record has gap=1.
- Timestamp wrap and enable: TS_W=4, trace_en toggled → ts wraps 15→0; no records for cycles with trace_en=0.
- Mid-stream reset: assert rst while the serializer is in EMIT with FIFO holding 3 entries → next cycle out_valid=0, drop_cnt=0, overflow=0. A following event gets ts counted from 0.
